cmp_share_arbiter: RTL
======================

// Module: cmp_share_arbiter
// PURPOSE
//  Shares one N-bit magnitude-compare datapath among NREQ requesters.
//  - Round-robin arbitration; captures the winner's operand pair.
//  - Returns the registered gt/eq/lt result, tagged with requester id, over a valid/ready response port.
//  - Sits between client blocks (sorters, limit checkers) and the single comparator instance.
// PARAMETERS
//  N       32  operand width, bits (N >= 1)
//  NREQ    4   number of requesters (NREQ >= 2)
//  SIGNED  0   0: unsigned compare; 1: two's-complement compare
//  IDW     localparam = $clog2(NREQ), width of rsp_id
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        synchronous reset, active low
//  req        in   NREQ     req[i]: requester i has an operand pair pending
//  ip1_bus    in   NREQ*N   requester i operand 1 at [i*N +: N]
//  ip2_bus    in   NREQ*N   requester i operand 2 at [i*N +: N]
//  gnt        out  NREQ     one-hot, one-cycle pulse: operands of requester i captured
//  busy       out  1        1 whenever FSM is not IDLE
//  rsp_valid  out  1        result valid
//  rsp_ready  in   1        consumer accepts result
//  rsp_id     out  IDW      index of requester owning the result
//  rsp_gt     out  1        ip1 > ip2
//  rsp_eq     out  1        ip1 == ip2
//  rsp_lt     out  1        ip1 < ip2
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): FSM=IDLE, rr pointer=0.
//   - gnt=0, busy=0, rsp_valid=0, rsp_id=0, rsp_gt/eq/lt=0, operand regs=0.
//   - Mid-operation reset discards the in-flight compare; no response is ever issued for it.
//  FSM, all outputs registered:
//   IDLE : if |req, pick the winner and go to GRANT; else stay.
//          - Winner = first set req[k] searching k = ptr, ptr+1, ... NREQ-1, 0, ... (wraps).
//          - Same edge: capture ip1/ip2 slices of the winner into op regs; capture winner id.
//   GRANT: gnt[id]=1 for exactly this cycle; -> CMP.
//   CMP  : compare op regs (SIGNED selects signedness).
//          - Register exactly one of gt/eq/lt high; set rsp_valid=1; -> RESP.
//   RESP : hold rsp_valid, rsp_id, flags stable until rsp_valid && rsp_ready at an edge.
//          - On that edge: rsp_valid=0, ptr = (id==NREQ-1) ? 0 : id+1, -> IDLE.
//          - Flags keep their last value after the handshake (don't-care while rsp_valid=0).
//  Latency: req sampled at IDLE edge t -> gnt during cycle t+1 -> rsp_valid from cycle t+3.
//   - Min 4 cycles per compare: IDLE, GRANT, CMP, RESP with rsp_ready=1.
//  Requester rules:
//   - Hold req and operands stable until gnt.
//   - Drop req on the cycle after gnt unless issuing a new request.
//   - req still high when FSM re-enters IDLE is a new request.
//  req changes outside IDLE are ignored; there is no queue and no request is lost while it is held.
//  Operand changes after capture do not affect the result.
//  Fairness: a continuously asserted req is granted within NREQ arbitration rounds.
//  Flags one-hot whenever rsp_valid=1; never two set, never none set.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles, req=4'b1111 -> gnt=0, busy=0, rsp_valid=0 throughout.
//  2 Single unsigned (N=32, SIGNED=0): req[2]=1, ip1=32'hFFFF_FFFF, ip2=32'h0000_0001
//    -> gnt=4'b0100 in cycle t+1; rsp_valid at t+3; id=2; gt=1.
//  3 Round-robin: req=4'b1111 held, rsp_ready=1
//    -> grants in order 0,1,2,3,0; each response tagged with the matching id.
//  4 Backpressure: rsp_ready=0 for 5 cycles with ip1=ip2=32'h1234_5678
//    -> rsp_valid, id, eq=1 stable all 5 cycles; no gnt issued; IDLE one cycle after rsp_ready=1.
//  5 Signed (SIGNED=1): ip1=32'h8000_0000, ip2=32'h0000_0001 -> lt=1.
//    Same operands with SIGNED=0 -> gt=1.
//  6 Reset mid-op: rst_n=0 during CMP -> rsp_valid never asserts.
//    - Next req[3] alone is granted with ptr=0 search: gnt=4'b1000.

Source files
------------

// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter: round-robin sharing of one magnitude comparator among NREQ requesters,
// returning a registered gt/eq/lt result tagged with the owner id over a valid/ready port.
module cmp_share_arbiter #(
    parameter int N = 32,
    parameter int NREQ = 4,
    parameter bit SIGNED = 1'b0,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] ip1_bus,
    input  logic [NREQ*N-1:0] ip2_bus,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_gt,
    output logic              rsp_eq,
    output logic              rsp_lt
);
    typedef enum logic [1:0] {IDLE, GRANT, CMP, RESP} state_t;
    state_t state_q;
    logic [IDW-1:0] ptr_q, win_d;
    logic found_d;
    logic [IDW:0] idx;
    logic [N-1:0] op1_q, op2_q;
    logic [N-1:0] ip1_a [NREQ];
    logic [N-1:0] ip2_a [NREQ];
    logic gt_d, lt_d, eq_d;

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign ip1_a[i] = ip1_bus[i*N +: N];
        assign ip2_a[i] = ip2_bus[i*N +: N];
    end

    // Rotating search from ptr_q; idx wraps modulo NREQ so the first hit wins.
    always_comb begin
        found_d = 1'b0;
        win_d = '0;
        idx = '0;
        for (int j = 0; j < NREQ; j++) begin
            idx = {1'b0, ptr_q} + (IDW+1)'(j);
            if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
            if (!found_d && req[idx[IDW-1:0]]) begin
                found_d = 1'b1;
                win_d = idx[IDW-1:0];
            end
        end
    end

    assign gt_d = SIGNED ? ($signed(op1_q) > $signed(op2_q)) : (op1_q > op2_q);
    assign lt_d = SIGNED ? ($signed(op1_q) < $signed(op2_q)) : (op1_q < op2_q);
    assign eq_d = (op1_q == op2_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_gt    <= 1'b0;
            rsp_eq    <= 1'b0;
            rsp_lt    <= 1'b0;
            op1_q     <= '0;
            op2_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (found_d) begin
                    state_q <= GRANT;
                    busy    <= 1'b1;
                    gnt     <= NREQ'(1) << win_d;
                    rsp_id  <= win_d;
                    op1_q   <= ip1_a[win_d];
                    op2_q   <= ip2_a[win_d];
                end
                GRANT: begin
                    state_q <= CMP;
                    gnt     <= '0;
                end
                CMP: begin
                    state_q   <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_gt    <= gt_d;
                    rsp_eq    <= eq_d;
                    rsp_lt    <= lt_d;
                end
                RESP: if (rsp_ready) begin
                    state_q   <= IDLE;
                    busy      <= 1'b0;
                    rsp_valid <= 1'b0;
                    ptr_q     <= (rsp_id == IDW'(NREQ-1)) ? '0 : rsp_id + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
